// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared processor types for the memory/write-back boundary
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_POP_FLAGS = 3'd1,
        SEQ_POP_LO    = 3'd2,
        SEQ_POP_HI    = 3'd3,
        SEQ_WAIT      = 3'd4,
        SEQ_REDIRECT  = 3'd5
    } seq_state_e;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    // Fixed successor of every active sequencer state; IDLE only leaves on a start
    function automatic seq_state_e seq_next(input seq_state_e s);
        case (s)
            SEQ_POP_FLAGS: return SEQ_POP_LO;
            SEQ_POP_LO:    return SEQ_POP_HI;
            SEQ_POP_HI:    return SEQ_WAIT;
            SEQ_WAIT:      return SEQ_REDIRECT;
            default:       return SEQ_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_return_sequencer.sv
// return_sequencer: pops flags and a 32-bit return PC from the stack for ret/rti
module return_sequencer
    import mem_wb_stage_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start_ret,
    input  logic       i_start_rti,
    input  logic       i_flush,
    input  logic [2:0] i_pop_data,
    output logic       o_busy,
    output logic       o_pop_req,
    output logic       o_pc_choose_memory,
    output logic       o_flags_restore_en,
    output logic [2:0] o_flags_restore
);

    seq_state_e r_state;
    seq_state_e w_next;
    logic       r_pop_req;
    logic       r_pc_choose;
    logic       r_flags_en;

    // Next state: flush aborts any sequence, rti outranks ret when starting
    always_comb begin
        w_next = i_flush ? SEQ_IDLE :
                 (r_state != SEQ_IDLE) ? seq_next(r_state) :
                 i_start_rti ? SEQ_POP_FLAGS :
                 i_start_ret ? SEQ_POP_LO : SEQ_IDLE;
    end

    // State plus outputs registered from the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SEQ_IDLE;
            r_pop_req   <= 1'b0;
            r_pc_choose <= 1'b0;
            r_flags_en  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pop_req   <= (w_next == SEQ_POP_FLAGS) || (w_next == SEQ_POP_LO) || (w_next == SEQ_POP_HI);
            r_pc_choose <= (w_next == SEQ_REDIRECT);
            r_flags_en  <= (w_next == SEQ_POP_LO) && (r_state == SEQ_POP_FLAGS);
        end
    end

    // Flags pop data arrives one cycle after its pop, i.e. during POP_LO of an rti
    assign o_busy             = (r_state != SEQ_IDLE);
    assign o_pop_req          = r_pop_req;
    assign o_pc_choose_memory = r_pc_choose;
    assign o_flags_restore_en = r_flags_en;
    assign o_flags_restore    = r_flags_en ? i_pop_data : 3'b000;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/write-back pipeline register with return sequencing
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [REG_AW-1:0] i_rdst,
    input  logic              i_reg_write,
    input  logic              i_wb_src_select,
    input  logic              i_ret_op,
    input  logic              i_rti_op,
    input  logic              i_flush,
    output logic              o_wb_en,
    output logic [REG_AW-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_seq_busy,
    output logic              o_pop_req,
    output logic              o_pc_choose_memory,
    output logic              o_flags_restore_en,
    output logic [2:0]        o_flags_restore
);

    logic              w_seq_active;
    logic              w_capture;
    logic              w_is_return;
    logic              w_start_ret;
    logic              w_start_rti;
    logic [DATA_W-1:0] w_wb_data;
    logic              r_wb_en;
    logic [REG_AW-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    // Capture is blocked while the sequencer stalls upstream or a flush is pending
    always_comb begin
        w_is_return = i_ret_op | i_rti_op;
        w_capture   = i_mem_valid & ~w_seq_active & ~i_flush;
        w_start_rti = w_capture & i_rti_op;
        w_start_ret = w_capture & i_ret_op & ~i_rti_op;
        w_wb_data   = (wb_src_e'(i_wb_src_select) == WB_SRC_MEM) ? i_mem_data : i_alu_result;
    end

    // Write port holds one cycle; returns never write the register file
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= w_capture & i_reg_write & ~w_is_return;
            if (w_capture) begin
                r_wb_addr <= i_rdst;
                r_wb_data <= w_wb_data;
            end
        end
    end

    return_sequencer u_seq (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start_ret        (w_start_ret),
        .i_start_rti        (w_start_rti),
        .i_flush            (i_flush),
        .i_pop_data         (i_mem_data[2:0]),
        .o_busy             (w_seq_active),
        .o_pop_req          (o_pop_req),
        .o_pc_choose_memory (o_pc_choose_memory),
        .o_flags_restore_en (o_flags_restore_en),
        .o_flags_restore    (o_flags_restore)
    );

    // Stall starts in the very cycle a return is accepted so upstream freezes at once
    assign o_seq_busy = i_rst_n & (w_seq_active | w_start_ret | w_start_rti);
    assign o_wb_en    = r_wb_en;
    assign o_wb_addr  = r_wb_addr;
    assign o_wb_data  = r_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, reg_write, src, ret_op, rti_op, flush;
    logic [15:0] alu, mdata;
    logic [2:0]  rdst;
    logic        wb_en, busy, pop, pcc, fen;
    logic [2:0]  wb_addr, fr;
    logic [15:0] wb_data;

    typedef struct packed {
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        busy;
        logic        pop;
        logic        pcc;
        logic        fen;
        logic [2:0]  fr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    int          m_left = 0;
    logic        m_rti = 1'b0;
    logic        m_wb_en = 1'b0;
    logic [2:0]  m_addr = '0;
    logic [15:0] m_data = '0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_mem_valid        (mem_valid),
        .i_alu_result       (alu),
        .i_mem_data         (mdata),
        .i_rdst             (rdst),
        .i_reg_write        (reg_write),
        .i_wb_src_select    (src),
        .i_ret_op           (ret_op),
        .i_rti_op           (rti_op),
        .i_flush            (flush),
        .o_wb_en            (wb_en),
        .o_wb_addr          (wb_addr),
        .o_wb_data          (wb_data),
        .o_seq_busy         (busy),
        .o_pop_req          (pop),
        .o_pc_choose_memory (pcc),
        .o_flags_restore_en (fen),
        .o_flags_restore    (fr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wb_en"}, 32'(wb_en), 0);
        chk({tag, ".wb_addr"}, 32'(wb_addr), 0);
        chk({tag, ".wb_data"}, 32'(wb_data), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".pop"}, 32'(pop), 0);
        chk({tag, ".pcc"}, 32'(pcc), 0);
        chk({tag, ".fen"}, 32'(fen), 0);
        chk({tag, ".fr"}, 32'(fr), 0);
    endtask

    // Drive one cycle of inputs, push what the model expects this cycle, advance the model
    task automatic step(input logic v, input logic s, input logic [15:0] a, input logic [15:0] md,
                        input logic [2:0] rd, input logic rw, input logic rt, input logic ri, input logic fl);
        exp_t e;
        logic cap;
        @(posedge clk);
        #1;
        mem_valid = v; src = s; alu = a; mdata = md; rdst = rd;
        reg_write = rw; ret_op = rt; rti_op = ri; flush = fl;
        cap = v && (m_left == 0) && !fl;
        e.wb_en   = m_wb_en;
        e.wb_addr = m_addr;
        e.wb_data = m_data;
        e.busy    = (m_left > 0) || (cap && (rt || ri));
        e.pop     = (m_left >= 3);
        e.pcc     = (m_left == 1);
        e.fen     = m_rti && (m_left == 4);
        e.fr      = e.fen ? md[2:0] : 3'b000;
        exp_q.push_back(e);
        if (fl) m_left = 0;
        else if (m_left > 0) m_left--;
        else if (cap && ri) begin m_left = 5; m_rti = 1'b1; end
        else if (cap && rt) begin m_left = 4; m_rti = 1'b0; end
        m_wb_en = cap && rw && !(rt || ri);
        if (cap) begin
            m_addr = rd;
            m_data = s ? md : a;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
    endtask

    // Scoreboard: compare the DUT against the oldest expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_en", 32'(wb_en), 32'(e.wb_en));
            chk("wb_addr", 32'(wb_addr), 32'(e.wb_addr));
            chk("wb_data", 32'(wb_data), 32'(e.wb_data));
            chk("seq_busy", 32'(busy), 32'(e.busy));
            chk("pop_req", 32'(pop), 32'(e.pop));
            chk("pc_choose", 32'(pcc), 32'(e.pcc));
            chk("flags_en", 32'(fen), 32'(e.fen));
            chk("flags", 32'(fr), 32'(e.fr));
        end
    end

    initial begin
        rst_n = 1'b0;
        {mem_valid, reg_write, src, ret_op, rti_op, flush} = '0;
        alu = '0; mdata = '0; rdst = '0;
        #23;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 16'h1234, 16'h0, 3'd5, 1, 0, 0, 0);
        idle(2);
        step(1, 1, 16'h1111, 16'hBEEF, 3'd2, 1, 0, 0, 0);
        idle(2);
        step(1, 0, 16'hA5A5, 16'h0, 3'd7, 0, 0, 0, 0);
        step(1, 0, 16'h0001, 16'h0, 3'd1, 1, 0, 0, 0);
        step(1, 1, 16'h0002, 16'h7777, 3'd3, 1, 0, 0, 0);
        step(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1);
        step(1, 0, 16'h4444, 16'h0, 3'd4, 1, 0, 0, 1);
        idle(1);
        step(1, 0, 16'h0, 16'h0, 3'd6, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 16'hDEAD, 16'h0, 3'd1, 1, 0, 0, 0);
        step(1, 0, 16'h0, 16'h0, 3'd6, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 16'h0, 16'h0005, 3'd0, 0, 0, 0, 0);
        step(1, 0, 16'h0, 16'h0, 3'd6, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 16'h0, 16'h0002, 3'd0, 0, 0, 0, 0);
        step(1, 0, 16'h0, 16'h0, 3'd0, 0, 1, 0, 0);
        step(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1);
        idle(5);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 3'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        idle(8);
        step(1, 0, 16'h0, 16'h0, 3'd0, 0, 0, 1, 0);
        step(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
        step(0, 0, 16'h0, 16'h0006, 3'd0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        {mem_valid, reg_write, src, ret_op, rti_op, flush} = '0;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_left = 0; m_rti = 1'b0; m_wb_en = 1'b0; m_addr = '0; m_data = '0;
        exp_q.delete();
        step(1, 0, 16'h1234, 16'h0, 3'd5, 1, 0, 0, 0);
        idle(2);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
